// File: rtl/mem_arbiter.sv
// Byte-serial RAM controller arbitrating the single 8-bit RAM port between
// instruction fetch and the MEM stage; all outputs are registered.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  input  logic                  if_cancel_i,
  output logic                  if_done_o,
  output logic [31:0]           if_inst_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_size_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  output logic                  mem_done_o,
  output logic [31:0]           mem_rdata_o,
  output logic                  busy_o,
  output logic [ADDR_WIDTH-1:0] ram_a_o,
  output logic [7:0]            ram_dout_o,
  output logic                  ram_wr_o,
  input  logic [7:0]            ram_din_i
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic                  is_if_q, is_if_d;
  logic [2:0]            n_q, n_d;
  logic [2:0]            k_q, k_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           asm_q, asm_d;
  logic                  if_done_q, if_done_d;
  logic                  mem_done_q, mem_done_d;
  logic [31:0]           if_inst_q, if_inst_d;
  logic [31:0]           mem_rdata_q, mem_rdata_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] ram_a_q, ram_a_d;
  logic [7:0]            ram_dout_q, ram_dout_d;
  logic                  ram_wr_q, ram_wr_d;
  logic [1:0]            lane;

  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    is_if_d     = is_if_q;
    n_d         = n_q;
    k_d         = k_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = 1'b0;
    // Byte c arrives while k_q = c+1, so it lands in lane c.
    lane        = k_q[1:0] - 2'd1;

    case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          is_if_d = 1'b0;
          n_d     = size_to_n(mem_size_i);
          k_d     = 3'd0;
          asm_d   = 32'd0;
          wdata_d = mem_wdata_i;
          ram_a_d = mem_addr_i;
          if (mem_we_i) begin
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_wdata_i[7:0];
            state_d    = WRITE;
          end else begin
            state_d = READ;
          end
        end else if (if_req_i && !if_cancel_i) begin
          is_if_d = 1'b1;
          n_d     = 3'd4;
          k_d     = 3'd0;
          asm_d   = 32'd0;
          ram_a_d = if_addr_i;
          state_d = READ;
        end
      end

      READ: begin
        if (is_if_q && if_cancel_i) begin
          state_d = IDLE;
        end else begin
          k_d = k_q + 3'd1;
          if (k_q + 3'd1 < n_q) ram_a_d = ram_a_q + ADDR_ONE;
          if (k_q != 3'd0) asm_d = asm_q | ({24'd0, ram_din_i} << {lane, 3'b000});
          if (k_q == n_q) begin
            state_d = DONE;
            if (is_if_q) begin
              if_inst_d = asm_d;
              if_done_d = 1'b1;
            end else begin
              mem_rdata_d = asm_d;
              mem_done_d  = 1'b1;
            end
          end
        end
      end

      WRITE: begin
        k_d = k_q + 3'd1;
        if (k_q + 3'd1 < n_q) begin
          ram_a_d    = ram_a_q + ADDR_ONE;
          ram_wr_d   = 1'b1;
          ram_dout_d = wdata_q[15:8];
          wdata_d    = wdata_q >> 8;
        end else begin
          state_d    = DONE;
          mem_done_d = 1'b1;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      is_if_q     <= 1'b0;
      n_q         <= 3'd0;
      k_q         <= 3'd0;
      wdata_q     <= 32'd0;
      asm_q       <= 32'd0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
      busy_q      <= 1'b0;
      ram_a_q     <= '0;
      ram_dout_q  <= 8'd0;
      ram_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_if_q     <= is_if_d;
      n_q         <= n_d;
      k_q         <= k_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
      busy_q      <= busy_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
    end
  end

  assign if_done_o   = if_done_q;
  assign if_inst_o   = if_inst_q;
  assign mem_done_o  = mem_done_q;
  assign mem_rdata_o = mem_rdata_q;
  assign busy_o      = busy_q;
  assign ram_a_o     = ram_a_q;
  assign ram_dout_o  = ram_dout_q;
  assign ram_wr_o    = ram_wr_q;

endmodule
